// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Write-back arbiter: multiplier results take priority, ALU results
//            bypass or wait in an in-order queue for a free write slot.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mul_wb_oper,
    input  logic        mul_wb_writereg,
    input  logic [4:0]  mul_wb_regdest,
    input  logic [31:0] mul_wb_wbvalue,
    input  logic        alu_wb_oper,
    input  logic        alu_wb_writereg,
    input  logic [4:0]  alu_wb_regdest,
    input  logic [31:0] alu_wb_wbvalue,
    output logic        wb_alu_stall,
    output logic        wb_rf_writereg,
    output logic [4:0]  wb_rf_regdest,
    output logic [31:0] wb_rf_wbvalue,
    output logic        wb_overflow
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW + 1)'(DEPTH);

    logic [36:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_rf_writereg;
    logic [4:0]    r_rf_regdest;
    logic [31:0]   r_rf_wbvalue;

    logic          w_mul_cand;
    logic          w_alu_cand;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_queue_path;
    logic          w_push;
    logic          w_drop;
    logic          w_sel_valid;
    logic [4:0]    w_sel_regdest;
    logic [31:0]   w_sel_wbvalue;
    logic [36:0]   w_head;

    // Register 0 is hardwired, so writes to it are never candidates.
    assign w_mul_cand = mul_wb_oper & mul_wb_writereg & (mul_wb_regdest != 5'd0);
    assign w_alu_cand = alu_wb_oper & alu_wb_writereg & (alu_wb_regdest != 5'd0);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);
    assign w_head  = r_mem[r_rd_ptr];

    // The head drains only in slots the multiplier leaves free; an ALU result
    // must queue whenever it cannot be written next without overtaking.
    assign w_pop        = ~w_mul_cand & ~w_empty;
    assign w_queue_path = w_alu_cand & (w_mul_cand | ~w_empty);
    assign w_push       = w_queue_path & (~w_full | w_pop);
    assign w_drop       = w_queue_path & w_full & ~w_pop;

    always_comb begin
        w_sel_valid   = 1'b0;
        w_sel_regdest = r_rf_regdest;
        w_sel_wbvalue = r_rf_wbvalue;
        if (w_mul_cand) begin
            w_sel_valid   = 1'b1;
            w_sel_regdest = mul_wb_regdest;
            w_sel_wbvalue = mul_wb_wbvalue;
        end else if (!w_empty) begin
            w_sel_valid   = 1'b1;
            w_sel_regdest = w_head[36:32];
            w_sel_wbvalue = w_head[31:0];
        end else if (w_alu_cand) begin
            w_sel_valid   = 1'b1;
            w_sel_regdest = alu_wb_regdest;
            w_sel_wbvalue = alu_wb_wbvalue;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {alu_wb_regdest, alu_wb_wbvalue};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_rf_writereg <= 1'b0;
            r_rf_regdest  <= 5'd0;
            r_rf_wbvalue  <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_rf_writereg <= w_sel_valid;
            r_rf_regdest  <= w_sel_regdest;
            r_rf_wbvalue  <= w_sel_wbvalue;
        end
    end

    assign wb_alu_stall   = w_full;
    assign wb_rf_writereg = r_rf_writereg;
    assign wb_rf_regdest  = r_rf_regdest;
    assign wb_rf_wbvalue  = r_rf_wbvalue;
    assign wb_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed and short random stimulus for wb_arbiter, checked every
//            cycle against a queue-based reference plus literal spot checks.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        mul_oper, mul_wr, alu_oper, alu_wr;
    logic [4:0]  mul_rd, alu_rd;
    logic [31:0] mul_val, alu_val;
    logic        stall, rf_we, ovf;
    logic [4:0]  rf_rd;
    logic [31:0] rf_val;

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clock           (clk),
        .reset           (rst),
        .mul_wb_oper     (mul_oper),
        .mul_wb_writereg (mul_wr),
        .mul_wb_regdest  (mul_rd),
        .mul_wb_wbvalue  (mul_val),
        .alu_wb_oper     (alu_oper),
        .alu_wb_writereg (alu_wr),
        .alu_wb_regdest  (alu_rd),
        .alu_wb_wbvalue  (alu_val),
        .wb_alu_stall    (stall),
        .wb_rf_writereg  (rf_we),
        .wb_rf_regdest   (rf_rd),
        .wb_rf_wbvalue   (rf_val),
        .wb_overflow     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending ALU results as a plain queue, outputs as last write.
    typedef struct packed { logic [4:0] rd; logic [31:0] v; } entry_t;
    entry_t      q[$];
    logic        m_we  = 1'b0;
    logic [4:0]  m_rd  = '0;
    logic [31:0] m_val = '0;
    logic        m_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_we = 1'b0; m_rd = '0; m_val = '0; m_ovf = 1'b0;
        end else begin
            bit mc, ac, popped, was_full;
            int n0;
            mc = mul_oper && mul_wr && (mul_rd != 0);
            ac = alu_oper && alu_wr && (alu_rd != 0);
            n0 = q.size();
            was_full = (n0 == DEPTH);
            popped = 0;
            m_we = 1'b0;
            if (mc) begin
                m_we = 1'b1; m_rd = mul_rd; m_val = mul_val;
            end else if (n0 > 0) begin
                entry_t e;
                e = q.pop_front();
                popped = 1;
                m_we = 1'b1; m_rd = e.rd; m_val = e.v;
            end else if (ac) begin
                m_we = 1'b1; m_rd = alu_rd; m_val = alu_val;
            end
            if (ac && (mc || n0 > 0)) begin
                if (was_full && !popped) m_ovf = 1'b1;
                else q.push_back('{rd: alu_rd, v: alu_val});
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp("model_we",    {31'd0, rf_we}, {31'd0, m_we});
            cmp("model_rd",    {27'd0, rf_rd}, {27'd0, m_rd});
            cmp("model_val",   rf_val, m_val);
            cmp("model_stall", {31'd0, stall}, {31'd0, q.size() == DEPTH});
            cmp("model_ovf",   {31'd0, ovf},   {31'd0, m_ovf});
        end
    end

    task automatic drv(input logic mo, input logic mw, input logic [4:0] mr, input logic [31:0] mv,
                       input logic ao, input logic aw, input logic [4:0] ar, input logic [31:0] av);
        mul_oper = mo; mul_wr = mw; mul_rd = mr; mul_val = mv;
        alu_oper = ao; alu_wr = aw; alu_rd = ar; alu_val = av;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    endtask

    task automatic lit_out(input string name, input logic we, input logic [4:0] rd, input logic [31:0] v);
        cmp({name, "_we"}, {31'd0, rf_we}, {31'd0, we});
        cmp({name, "_rd"}, {27'd0, rf_rd}, {27'd0, rd});
        cmp({name, "_val"}, rf_val, v);
    endtask

    initial begin
        rst = 1'b1;
        mul_oper = 0; mul_wr = 0; mul_rd = '0; mul_val = '0;
        alu_oper = 0; alu_wr = 0; alu_rd = '0; alu_val = '0;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        lit_out("reset", 1'b0, 5'd0, 32'd0);
        cmp("reset_stall", {31'd0, stall}, 32'd0);
        cmp("reset_ovf",   {31'd0, ovf},   32'd0);
        rst = 1'b0;
        idle();

        // Single multiplier result, 1-cycle latency, then hold with we=0
        drv(1, 1, 5'd5, 32'h30, 0, 0, 5'd0, 32'd0);
        lit_out("mul_only", 1'b1, 5'd5, 32'h30);
        idle();
        lit_out("mul_hold", 1'b0, 5'd5, 32'h30);

        // Simultaneous mul and ALU: ALU waits one slot
        drv(1, 1, 5'd3, 32'h11, 1, 1, 5'd4, 32'h22);
        lit_out("both_mul", 1'b1, 5'd3, 32'h11);
        idle();
        lit_out("both_alu", 1'b1, 5'd4, 32'h22);
        idle();

        // Queue fills behind a multiplier burst, then drains in order
        for (int i = 1; i <= 4; i++)
            drv(1, 1, 5'(10 + i), 32'h100 + i, 1, 1, 5'(i), 32'hA0 + i);
        cmp("burst_stall_full", {31'd0, stall}, 32'd1);
        drv(1, 1, 5'd15, 32'h105, 0, 0, 5'd0, 32'd0);
        lit_out("burst_mul5", 1'b1, 5'd15, 32'h105);
        for (int i = 1; i <= 4; i++) begin
            idle();
            lit_out($sformatf("burst_r%0d", i), 1'b1, 5'(i), 32'hA0 + i);
        end
        cmp("burst_stall_clear", {31'd0, stall}, 32'd0);
        idle();

        // Full queue: drop while mul blocks the pop, accept when a pop frees a slot
        for (int i = 0; i < 4; i++)
            drv(1, 1, 5'(20 + i), 32'hC0 + i, 1, 1, 5'(24 + i), 32'hB0 + i);
        drv(1, 1, 5'd28, 32'hC4, 1, 1, 5'd9, 32'hFF);
        cmp("drop_ovf", {31'd0, ovf}, 32'd1);
        drv(0, 0, 5'd0, 32'd0, 1, 1, 5'd8, 32'h88);
        lit_out("full_poppush", 1'b1, 5'd24, 32'hB0);
        cmp("full_poppush_stall", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 4; i++) idle();
        lit_out("drain_last", 1'b1, 5'd8, 32'h88);
        cmp("ovf_sticky", {31'd0, ovf}, 32'd1);
        idle();

        // Non-candidates are discarded
        drv(0, 0, 5'd0, 32'd0, 1, 1, 5'd0, 32'h55);
        cmp("r0_nowrite", {31'd0, rf_we}, 32'd0);
        drv(0, 0, 5'd0, 32'd0, 1, 0, 5'd7, 32'h77);
        cmp("nowr_nowrite", {31'd0, rf_we}, 32'd0);
        drv(1, 1, 5'd1, 32'h1, 1, 1, 5'd0, 32'h55);
        drv(1, 1, 5'd2, 32'h2, 1, 0, 5'd7, 32'h77);
        cmp("discard_count", {31'd0, stall}, 32'd0);
        idle();

        // Reset with entries queued and a write in flight
        for (int i = 0; i < 3; i++)
            drv(1, 1, 5'(11 + i), 32'hD0 + i, 1, 1, 5'(14 + i), 32'hE0 + i);
        rst = 1'b1;
        drv(1, 1, 5'd6, 32'h66, 0, 0, 5'd0, 32'd0);
        rst = 1'b0;
        lit_out("midreset", 1'b0, 5'd0, 32'd0);
        cmp("midreset_ovf",   {31'd0, ovf},   32'd0);
        cmp("midreset_stall", {31'd0, stall}, 32'd0);
        drv(0, 0, 5'd0, 32'd0, 1, 1, 5'd2, 32'h7);
        lit_out("post_reset_bypass", 1'b1, 5'd2, 32'h7);
        idle();
        lit_out("post_reset_idle", 1'b0, 5'd2, 32'h7);

        // Short random mix, checked by the reference only
        for (int i = 0; i < 300; i++) begin
            drv(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)),      1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 7)), $urandom);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
